virtual_ds2431_mem_write_scratchpad: RTL and testbench

Command engine for the DS2431 Write Scratchpad function (0x0F). The ROM/function layer detects the command byte and starts the engine. It then receives TA1, TA2 and up to 8 data bytes through the byte-level 1-Wire I/O layer, fills the 8-byte scratchpad, and builds TA1/TA2/ES. When the scratchpad end is reached, it returns the inverted CRC16 to the master. Its outputs feed the Read Scratchpad and Copy Scratchpad engines.

---
 rtl/virtual_ds2431_mem_write_scratchpad_if.sv | 25 ++
 rtl/virtual_ds2431_mem_write_scratchpad.sv | 171 +++++++++++++++++
 tb/tb_virtual_ds2431_mem_write_scratchpad.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/virtual_ds2431_mem_write_scratchpad_if.sv
// Byte-level 1-Wire handshake between the Write Scratchpad engine (master)
// and the byte I/O layer (slave).
interface virtual_ds2431_mem_write_scratchpad_if;
    logic [7:0] rxDat;
    logic       ByteTransDone;
    logic       nRxTx;
    logic       transTrig;
    logic [7:0] sentDat;

    modport master (
        input  rxDat,
        input  ByteTransDone,
        output nRxTx,
        output transTrig,
        output sentDat
    );

    modport slave (
        output rxDat,
        output ByteTransDone,
        input  nRxTx,
        input  transTrig,
        input  sentDat
    );
endinterface

// File: rtl/virtual_ds2431_mem_write_scratchpad.sv
// DS2431 Write Scratchpad (0x0F) command engine: receives TA1/TA2/data, fills the
// scratchpad, maintains TA1/TA2/ES and returns the inverted CRC16 to the master.
module virtual_ds2431_mem_write_scratchpad (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmdRunTrig,
    input  logic        masterRst,
    virtual_ds2431_mem_write_scratchpad_if.master byteIo,
    output logic [63:0] Scratchpad,
    output logic [7:0]  TA1,
    output logic [7:0]  TA2,
    output logic [7:0]  ES,
    output logic        cmdDone
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        RX_TA1  = 3'd2,
        RX_TA2  = 3'd3,
        RX_DATA = 3'd4,
        TX_CRCL = 3'd5,
        TX_CRCH = 3'd6,
        DONE    = 3'd7
    } state_t;

    // CRC-16/MAXIM, reflected 0xA001, one byte folded LSB first
    function automatic logic [15:0] crc16Fold(input logic [15:0] crcIn, input logic [7:0] dataIn);
        logic [15:0] c;
        c = crcIn;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ dataIn[i]) begin
                c = {1'b0, c[15:1]} ^ 16'hA001;
            end else begin
                c = {1'b0, c[15:1]};
            end
        end
        return c;
    endfunction

    state_t      stateR;
    logic [15:0] crcR;
    logic [2:0]  offsetR;
    logic        trigPrevR;
    logic        btdPrevR;
    logic        trigEdgeS;
    logic        btdEdgeS;
    logic [15:0] crcNextS;

    assign trigEdgeS = cmdRunTrig & ~trigPrevR;
    assign btdEdgeS  = byteIo.ByteTransDone & ~btdPrevR;
    assign crcNextS  = crc16Fold(crcR, byteIo.rxDat);

    // Previous-cycle copies of the trigger inputs for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trigPrevR <= 1'b0;
            btdPrevR  <= 1'b0;
        end else begin
            trigPrevR <= cmdRunTrig;
            btdPrevR  <= byteIo.ByteTransDone;
        end
    end

    // Command FSM with registered handshake, scratchpad and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateR           <= IDLE;
            crcR             <= 16'h0000;
            offsetR          <= 3'd0;
            byteIo.nRxTx     <= 1'b0;
            byteIo.transTrig <= 1'b0;
            byteIo.sentDat   <= 8'hFF;
            Scratchpad       <= 64'h0;
            TA1              <= 8'h00;
            TA2              <= 8'h00;
            ES               <= 8'h00;
            cmdDone          <= 1'b0;
        end else begin
            byteIo.transTrig <= 1'b0;
            // Bus reset beats a simultaneous restart; registers keep partial progress
            if ((stateR != IDLE) && masterRst) begin
                stateR         <= IDLE;
                byteIo.nRxTx   <= 1'b0;
                byteIo.sentDat <= 8'hFF;
            end else if ((stateR != IDLE) && trigEdgeS) begin
                stateR         <= CMD;
                cmdDone        <= 1'b0;
                crcR           <= 16'h0000;
                byteIo.nRxTx   <= 1'b0;
                byteIo.sentDat <= 8'hFF;
            end else begin
                case (stateR)
                    IDLE: begin
                        if (trigEdgeS) begin
                            cmdDone <= 1'b0;
                            crcR    <= 16'h0000;
                            stateR  <= CMD;
                        end
                    end
                    CMD: begin
                        crcR             <= crc16Fold(crcR, 8'h0F);
                        byteIo.nRxTx     <= 1'b0;
                        byteIo.transTrig <= 1'b1;
                        stateR           <= RX_TA1;
                    end
                    RX_TA1: begin
                        if (btdEdgeS) begin
                            TA1              <= byteIo.rxDat;
                            crcR             <= crcNextS;
                            offsetR          <= byteIo.rxDat[2:0];
                            ES               <= {5'b00000, byteIo.rxDat[2:0]};
                            byteIo.transTrig <= 1'b1;
                            stateR           <= RX_TA2;
                        end
                    end
                    RX_TA2: begin
                        if (btdEdgeS) begin
                            TA2              <= byteIo.rxDat;
                            crcR             <= crcNextS;
                            ES[5]            <= 1'b1;
                            byteIo.transTrig <= 1'b1;
                            stateR           <= RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        if (btdEdgeS) begin
                            Scratchpad[{offsetR, 3'b000} +: 8] <= byteIo.rxDat;
                            crcR    <= crcNextS;
                            ES[2:0] <= offsetR;
                            // The CRC request goes out on the same edge so the master sees no gap
                            if (offsetR == 3'd7) begin
                                ES[5]            <= 1'b0;
                                byteIo.nRxTx     <= 1'b1;
                                byteIo.sentDat   <= ~crcNextS[7:0];
                                byteIo.transTrig <= 1'b1;
                                stateR           <= TX_CRCL;
                            end else begin
                                ES[5]            <= 1'b1;
                                offsetR          <= offsetR + 3'd1;
                                byteIo.transTrig <= 1'b1;
                            end
                        end
                    end
                    TX_CRCL: begin
                        if (btdEdgeS) begin
                            byteIo.sentDat   <= ~crcR[15:8];
                            byteIo.transTrig <= 1'b1;
                            stateR           <= TX_CRCH;
                        end
                    end
                    TX_CRCH: begin
                        if (btdEdgeS) begin
                            stateR <= DONE;
                        end
                    end
                    DONE: begin
                        cmdDone        <= 1'b1;
                        byteIo.sentDat <= 8'hFF;
                        byteIo.nRxTx   <= 1'b0;
                        stateR         <= IDLE;
                    end
                    default: begin
                        stateR <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_virtual_ds2431_mem_write_scratchpad.sv
// Self-checking bench: the bench plays the byte I/O layer and compares against a
// table-based CRC16 model and a byte-array scratchpad model.
module tb_virtual_ds2431_mem_write_scratchpad;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmdRunTrig;
    logic        masterRst;
    logic [63:0] Scratchpad;
    logic [7:0]  TA1, TA2, ES;
    logic        cmdDone;
    int          nChecks = 0;
    int          nErrors = 0;

    virtual_ds2431_mem_write_scratchpad_if busIf();

    virtual_ds2431_mem_write_scratchpad dut (
        .clk        (clk),
        .rst        (rst),
        .cmdRunTrig (cmdRunTrig),
        .masterRst  (masterRst),
        .byteIo     (busIf.master),
        .Scratchpad (Scratchpad),
        .TA1        (TA1),
        .TA2        (TA2),
        .ES         (ES),
        .cmdDone    (cmdDone)
    );

    always #5 clk = ~clk;

    logic [15:0] crcTab [256];
    logic [7:0]  mSp [8];
    logic [7:0]  mTa1, mTa2, mEs;
    logic        mDone;

    typedef struct {
        logic [7:0]  ta1;
        logic [7:0]  ta2;
        logic [63:0] dat;
        int          abortAt;
        logic [63:0] expSp;
        logic [7:0]  expEs;
        logic        expDone;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] crcAdd(input logic [15:0] c, input logic [7:0] b);
        return (c >> 8) ^ crcTab[c[7:0] ^ b];
    endfunction

    function automatic logic [63:0] spModel();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = mSp[i];
        return r;
    endfunction

    task automatic resetModel();
        for (int i = 0; i < 8; i++) mSp[i] = 8'h00;
        mTa1 = 8'h00; mTa2 = 8'h00; mEs = 8'h00; mDone = 1'b0;
    endtask

    task automatic checkModel(input string tag);
        chk({tag, "_sp"},   Scratchpad, spModel());
        chk({tag, "_ta1"},  TA1, mTa1);
        chk({tag, "_ta2"},  TA2, mTa2);
        chk({tag, "_es"},   ES, mEs);
        chk({tag, "_done"}, cmdDone, mDone);
    endtask

    task automatic checkReset(input string tag);
        chk({tag, "_nRxTx"},     busIf.nRxTx, 1'b0);
        chk({tag, "_transTrig"}, busIf.transTrig, 1'b0);
        chk({tag, "_sentDat"},   busIf.sentDat, 8'hFF);
        chk({tag, "_sp"},        Scratchpad, 64'h0);
        chk({tag, "_ta1"},       TA1, 8'h00);
        chk({tag, "_ta2"},       TA2, 8'h00);
        chk({tag, "_es"},        ES, 8'h00);
        chk({tag, "_done"},      cmdDone, 1'b0);
    endtask

    task automatic waitTrig(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (busIf.transTrig === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            nChecks++;
            nErrors++;
            $display("FAIL trig_timeout: got no transTrig within 20 cycles, expected a request");
        end
    endtask

    // Acts as the byte layer for one requested transfer
    task automatic serveByte(input logic expTx, input logic [7:0] rxByte, output logic [7:0] got, output bit ok);
        waitTrig(ok);
        got = busIf.sentDat;
        if (!ok) return;
        chk("dir", busIf.nRxTx, expTx);
        @(negedge clk);
        chk("trig_pulse_width", busIf.transTrig, 1'b0);
        chk("sentDat_hold", busIf.sentDat, got);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        busIf.rxDat = rxByte;
        busIf.ByteTransDone = 1'b1;
        @(negedge clk);
        busIf.ByteTransDone = 1'b0;
        busIf.rxDat = 8'($urandom);
    endtask

    task automatic runCmd(input logic [7:0] ta1, input logic [7:0] ta2, input logic [63:0] dat,
                          input int abortAt, input bit rstAtCrc);
        int n, off, pulses;
        logic [15:0] crc;
        logic [7:0] got, exp8;
        bit ok;
        off = int'(ta1[2:0]);
        n = 8 - off;
        chk("pre_done", cmdDone, mDone);
        cmdRunTrig = 1'b1;
        @(negedge clk);
        cmdRunTrig = 1'b0;
        chk("start_done_clear", cmdDone, 1'b0);
        chk("start_no_early_trig", busIf.transTrig, 1'b0);
        @(negedge clk);
        chk("start_latency", busIf.transTrig, 1'b1);
        mDone = 1'b0;
        crc = crcAdd(16'h0000, 8'h0F);
        serveByte(1'b0, ta1, got, ok);
        if (!ok) return;
        mTa1 = ta1;
        crc = crcAdd(crc, ta1);
        serveByte(1'b0, ta2, got, ok);
        if (!ok) return;
        mTa2 = ta2;
        crc = crcAdd(crc, ta2);
        for (int k = 0; k < n; k++) begin
            if (k == abortAt) begin
                waitTrig(ok);
                masterRst = 1'b1;
                @(negedge clk);
                masterRst = 1'b0;
                pulses = 0;
                repeat (5) begin
                    @(negedge clk);
                    if (busIf.transTrig) pulses++;
                end
                chk("abort_no_trig", pulses, 0);
                mEs = 8'h20 | 8'((k == 0) ? off : off + k - 1);
                checkModel("abort");
                return;
            end
            serveByte(1'b0, dat[8*k +: 8], got, ok);
            if (!ok) return;
            mSp[off + k] = dat[8*k +: 8];
            crc = crcAdd(crc, dat[8*k +: 8]);
        end
        mEs = 8'h07;
        if (rstAtCrc) begin
            waitTrig(ok);
            chk("crcl_dir", busIf.nRxTx, 1'b1);
            #2 rst = 1'b1;
            #1 checkReset("async_rst");
            @(negedge clk);
            rst = 1'b0;
            resetModel();
            @(negedge clk);
            checkReset("after_rst");
            return;
        end
        serveByte(1'b1, 8'($urandom), got, ok);
        if (!ok) return;
        exp8 = ~crc[7:0];
        chk("crc_lo", got, exp8);
        serveByte(1'b1, 8'($urandom), got, ok);
        if (!ok) return;
        exp8 = ~crc[15:8];
        chk("crc_hi", got, exp8);
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (cmdDone) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_seen", ok, 1'b1);
        mDone = 1'b1;
        checkModel("done");
        chk("idle_sentDat", busIf.sentDat, 8'hFF);
        chk("idle_nRxTx", busIf.nRxTx, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test, expected $finish before 400us");
        $fatal(1);
    end

    initial begin
        int pulses;
        for (int i = 0; i < 256; i++) begin
            logic [15:0] c;
            c = 16'(i);
            repeat (8) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
            crcTab[i] = c;
        end
        vecs[0] = '{8'h10, 8'h00, 64'h0807060504030201, -1, 64'h0807060504030201, 8'h07, 1'b1};
        vecs[1] = '{8'h00, 8'h00, 64'hFFFFFFFFFFFFFFFF, -1, 64'hFFFFFFFFFFFFFFFF, 8'h07, 1'b1};
        vecs[2] = '{8'h1D, 8'h00, 64'h0000000000CCBBAA, -1, 64'hCCBBAAFFFFFFFFFF, 8'h07, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 64'h0000000000002211,  2, 64'hCCBBAAFFFFFF2211, 8'h21, 1'b0};
        vecs[4] = '{8'h47, 8'h12, 64'h000000000000005A, -1, 64'h5ABBAAFFFFFF2211, 8'h07, 1'b1};
        vecs[5] = '{8'h03, 8'h44, 64'h0000000000000000,  0, 64'h5ABBAAFFFFFF2211, 8'h23, 1'b0};

        rst = 1'b1;
        cmdRunTrig = 1'b0;
        masterRst = 1'b0;
        busIf.rxDat = 8'h00;
        busIf.ByteTransDone = 1'b0;
        resetModel();
        repeat (3) @(negedge clk);
        checkReset("in_rst");
        rst = 1'b0;
        @(negedge clk);
        checkReset("post_rst");

        for (int v = 0; v < 6; v++) begin
            runCmd(vecs[v].ta1, vecs[v].ta2, vecs[v].dat, vecs[v].abortAt, 1'b0);
            chk($sformatf("vec%0d_sp", v),   Scratchpad, vecs[v].expSp);
            chk($sformatf("vec%0d_es", v),   ES, vecs[v].expEs);
            chk($sformatf("vec%0d_done", v), cmdDone, vecs[v].expDone);
            chk($sformatf("vec%0d_ta1", v),  TA1, vecs[v].ta1);
        end

        // Spurious byte completions while idle, then a long-held start trigger
        pulses = 0;
        repeat (4) begin
            busIf.rxDat = 8'($urandom);
            busIf.ByteTransDone = 1'b1;
            @(negedge clk);
            if (busIf.transTrig) pulses++;
            busIf.ByteTransDone = 1'b0;
            @(negedge clk);
            if (busIf.transTrig) pulses++;
        end
        chk("idle_btd_ignored", pulses, 0);
        checkModel("idle_btd");
        cmdRunTrig = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (busIf.transTrig) pulses++;
        end
        cmdRunTrig = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busIf.transTrig) pulses++;
        end
        chk("held_trig_single_start", pulses, 1);
        masterRst = 1'b1;
        @(negedge clk);
        masterRst = 1'b0;
        @(negedge clk);
        mDone = 1'b0;
        checkModel("held_trig");

        // Reset while the low CRC byte is requested, then a fresh full command
        runCmd(8'h02, 8'h31, 64'h0000665544332211, -1, 1'b1);
        runCmd(8'h08, 8'h00, {$urandom, $urandom}, -1, 1'b0);

        for (int r = 0; r < 20; r++) begin
            logic [7:0]  a1, a2;
            logic [63:0] d;
            int          ab;
            a1 = 8'($urandom);
            a2 = 8'($urandom);
            d  = {$urandom, $urandom};
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7 - a1[2:0])) : -1;
            runCmd(a1, a2, d, ab, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
